// File: rtl/caesar_stream_ctrl.sv
// Caesar-shift stream controller: config regs, frame FSM, shift datapath and an
// output FIFO with valid/ready on both sides.
module caesar_shift (
  input  logic [7:0] din,
  input  logic [4:0] key,
  input  logic       decrypt,
  output logic [7:0] dout
);
  logic [7:0] base;
  logic [5:0] off, s, k6;
  logic       is_letter;

  always_comb begin
    is_letter = 1'b0;
    base      = 8'h41;
    off       = '0;
    s         = '0;
    k6        = {1'b0, key};
    dout      = din;
    if (din >= 8'h41 && din <= 8'h5A) begin
      is_letter = 1'b1;
      base      = 8'h41;
    end else if (din >= 8'h61 && din <= 8'h7A) begin
      is_letter = 1'b1;
      base      = 8'h61;
    end
    if (is_letter) begin
      off = 6'(din - base);
      if (!decrypt) begin
        s = off + k6;
        if (s >= 6'd26) s = s - 6'd26;
      end else if (off >= k6) begin
        s = off - k6;
      end else begin
        // borrow folded in as +26 first so the 6-bit value never goes negative
        s = off + 6'd26 - k6;
      end
      dout = base + {2'b00, s};
    end
  end
endmodule

module caesar_stream_ctrl #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_key,
  input  logic             cfg_decrypt,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] char_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [4:0]       key_q, key_d;
  logic             dec_q, dec_d;
  logic             cfg_err_q, cfg_err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] char_q, char_d;
  logic [7:0]       data_q [FIFO_DEPTH];
  logic [7:0]       data_d [FIFO_DEPTH];
  logic             last_q [FIFO_DEPTH];
  logic             last_d [FIFO_DEPTH];

  logic       push, pop, cfg_ok;
  logic [7:0] shifted;

  caesar_shift u_shift (
    .din     (in_data),
    .key     (key_q),
    .decrypt (dec_q),
    .dout    (shifted)
  );

  assign in_ready   = (state_q != DRAIN) && (cnt_q < CW'(FIFO_DEPTH));
  assign out_valid  = (cnt_q != '0);
  assign out_data   = data_q[rd_ptr_q];
  assign out_last   = last_q[rd_ptr_q];
  assign busy       = (state_q != IDLE);
  assign char_count = char_q;
  assign cfg_err    = cfg_err_q;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign cfg_ok = (state_q == IDLE) && (cfg_key <= 5'd25) && !push;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    dec_d     = dec_q;
    cfg_err_d = cfg_we && !cfg_ok;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    char_d    = char_q;
    data_d    = data_q;
    last_d    = last_q;

    if (cfg_we && cfg_ok) begin
      key_d = cfg_key;
      dec_d = cfg_decrypt;
    end

    if (push) begin
      data_d[wr_ptr_q] = shifted;
      last_d[wr_ptr_q] = in_last;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // FIFO is always empty in IDLE, so the frame-start clear never races a pop
    if (state_q == IDLE && push) char_d = '0;
    else if (pop && char_q != '1) char_d = char_q + CNT_W'(1);

    case (state_q)
      IDLE:    if (push) state_d = in_last ? DRAIN : ACTIVE;
      ACTIVE:  if (push && in_last) state_d = DRAIN;
      DRAIN:   if (cnt_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      dec_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      char_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      dec_q     <= dec_d;
      cfg_err_q <= cfg_err_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      char_q    <= char_d;
      data_q    <= data_d;
      last_q    <= last_d;
    end
  end
endmodule

// File: tb/tb_caesar_stream_ctrl.sv
// Directed bench for caesar_stream_ctrl: inputs driven after negedge, outputs sampled at negedge.
module tb_caesar_stream_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, cfg_decrypt, cfg_err;
  logic [4:0]  cfg_key;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] char_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  caesar_stream_ctrl #(.FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_key(cfg_key), .cfg_decrypt(cfg_decrypt), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .char_count(char_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [4:0] k, input logic d, input logic exp_err);
    cfg_we = 1'b1; cfg_key = k; cfg_decrypt = d;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err", cfg_err, exp_err);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d, input logic l);
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_last"}, out_last, l);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [7:0] d, input logic l, input logic [7:0] e);
    send_byte(d, l);
    pop_chk(tag, e, l);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_key = 0; cfg_decrypt = 0;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_char_count", char_count, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // key=3 encrypt, two-byte frame
    set_cfg(5'd3, 1'b0, 1'b0);
    send_byte(8'h41, 1'b0);
    chk("f1_valid", out_valid, 1);
    chk("f1_busy", busy, 1);
    send_byte(8'h62, 1'b1);
    pop_chk("f1_b0", 8'h44, 1'b0);
    pop_chk("f1_b1", 8'h65, 1'b1);
    chk("f1_count", char_count, 2);
    chk("f1_idle", busy, 0);
    chk("f1_empty", out_valid, 0);

    // wrap in both directions
    set_cfg(5'd1, 1'b0, 1'b0);
    xfer("enc_z", 8'h7A, 1'b1, 8'h61);
    set_cfg(5'd3, 1'b1, 1'b0);
    xfer("dec_a", 8'h61, 1'b1, 8'h78);
    set_cfg(5'd25, 1'b1, 1'b0);
    xfer("dec_Z", 8'h5A, 1'b1, 8'h41);

    // non-letters pass through
    set_cfg(5'd5, 1'b0, 1'b0);
    xfer("bang", 8'h21, 1'b0, 8'h21);
    xfer("zero", 8'h30, 1'b0, 8'h30);
    xfer("ff", 8'hFF, 1'b1, 8'hFF);
    chk("f3_count", char_count, 3);
    set_cfg(5'd0, 1'b0, 1'b0);
    xfer("key0", 8'h51, 1'b1, 8'h51);

    // backpressure plus config rejected while ACTIVE
    set_cfg(5'd3, 1'b0, 1'b0);
    send_byte(8'h41, 1'b0);
    set_cfg(5'd7, 1'b0, 1'b1);
    send_byte(8'h42, 1'b0);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h43; in_last = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_head1", out_data, 8'h45);
    chk("bp_ready_back", in_ready, 1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp_head2", out_data, 8'h46);
    chk("bp_last", out_last, 1);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("bp_empty", out_valid, 0);
    chk("bp_idle", busy, 0);
    chk("bp_count", char_count, 3);

    // illegal key in IDLE, key unchanged
    set_cfg(5'd26, 1'b0, 1'b1);
    xfer("key_kept", 8'h41, 1'b1, 8'h44);

    // cfg write colliding with an in beat: byte uses old key, cfg rejected
    cfg_we = 1'b1; cfg_key = 5'd10; cfg_decrypt = 1'b0;
    in_valid = 1'b1; in_data = 8'h41; in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("coll_cfg_err", cfg_err, 1);
    pop_chk("coll", 8'h44, 1'b1);
    xfer("coll_key_kept", 8'h61, 1'b1, 8'h64);

    // reset mid-frame
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", char_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    xfer("post_rst_key0", 8'h4D, 1'b1, 8'h4D);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
